// File: rtl/sysahb_interconnect.sv
// Single-master AHB-Lite decoder/mux with built-in ERROR default slave and stall watchdog.
// Latency: combinational decode and data mux, zero added wait states for mapped slaves.
// Backpressure: bus HREADY follows the selected slave; default slave and watchdog abort insert one ERROR wait.
module sysahb_interconnect #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]   ADDR_BASE      = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]   ADDR_MASK      = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int                         TIMEOUT_CYCLES = 64
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [31:0]                sysahb_haddr,
  input  logic [1:0]                 sysahb_htrans,
  output logic                       sysahb_hready,
  output logic                       sysahb_hresp,
  output logic [31:0]                sysahb_hrdata,
  output logic [NUM_SLAVES-1:0]      hsel_s,
  input  logic [NUM_SLAVES-1:0]      hreadyout_s,
  input  logic [NUM_SLAVES-1:0]      hresp_s,
  input  logic [32*NUM_SLAVES-1:0]   hrdata_s,
  output logic                       timeout_flag,
  output logic [2:0]                 timeout_slave,
  output logic [NUM_SLAVES-1:0]      quarantine,
  input  logic                       timeout_clr
);

  // Data-phase select encoding: 0..7 are slave indices, then the default slave and "nothing".
  localparam logic [3:0] DSEL_DEF  = 4'd8;
  localparam logic [3:0] DSEL_NONE = 4'd9;

  localparam logic [1:0] DEF_IDLE = 2'd0;
  localparam logic [1:0] DEF_ERR1 = 2'd1;
  localparam logic [1:0] DEF_ERR2 = 2'd2;

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int WCNT_W  = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort fires on the stall cycle that would bring the count up to TIMEOUT_CYCLES.
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [3:0]            dsel_q, dsel_d;
  logic [1:0]            def_q, def_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [NUM_SLAVES-1:0] quarantine_q, quarantine_d;
  logic                  tflag_q, tflag_d;
  logic [2:0]            tslave_q, tslave_d;

  logic                  any_match;
  logic [2:0]            sel_idx;
  logic                  dsel_slv, slv_rdy, slv_resp;
  logic [31:0]           slv_rdata;
  logic                  stall, abort;

  // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY pairs, which decode identically.
  logic unused_htrans0;
  assign unused_htrans0 = sysahb_htrans[0];

  // Address decode: scan high to low so the lowest matching index ends up selected.
  always_comb begin
    hsel_s    = '0;
    any_match = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (((sysahb_haddr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) && !quarantine_q[i]) begin
        any_match = 1'b1;
        sel_idx   = 3'(i);
        hsel_s    = '0;
        hsel_s[i] = 1'b1;
      end
    end
  end

  // Pick out the response of the slave owning the current data phase.
  always_comb begin
    dsel_slv  = 1'b0;
    slv_rdy   = 1'b1;
    slv_resp  = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == 4'(i)) begin
        dsel_slv  = 1'b1;
        slv_rdy   = hreadyout_s[i];
        slv_resp  = hresp_s[i];
        slv_rdata = hrdata_s[32*i +: 32];
      end
    end
  end

  // Bus response mux driven purely from registered state and slave outputs.
  always_comb begin
    sysahb_hready = 1'b1;
    sysahb_hresp  = 1'b0;
    sysahb_hrdata = '0;
    if (dsel_slv) begin
      sysahb_hready = slv_rdy;
      sysahb_hresp  = slv_resp;
      sysahb_hrdata = slv_rdata;
    end else if (dsel_q == DSEL_DEF) begin
      case (def_q)
        DEF_ERR1: begin sysahb_hready = 1'b0; sysahb_hresp = 1'b1; end
        DEF_ERR2: begin sysahb_hready = 1'b1; sysahb_hresp = 1'b1; end
        default:  begin sysahb_hready = 1'b1; sysahb_hresp = 1'b0; end
      endcase
    end
  end

  assign stall = dsel_slv && !slv_rdy;
  assign abort = WDOG_EN && stall && (wcnt_q == WCNT_LAST);

  // Next-state: data-phase select, default-slave FSM, watchdog and quarantine bookkeeping.
  always_comb begin
    dsel_d = dsel_q;
    if (abort) begin
      // Hand the stuck data phase to the default slave so it terminates with ERROR.
      dsel_d = DSEL_DEF;
    end else if (sysahb_hready) begin
      if (any_match)              dsel_d = {1'b0, sel_idx};
      else if (sysahb_htrans[1])  dsel_d = DSEL_DEF;
      else                        dsel_d = DSEL_NONE;
    end

    if (abort)                                                    def_d = DEF_ERR1;
    else if (sysahb_hready && !any_match && sysahb_htrans[1])     def_d = DEF_ERR1;
    else if (def_q == DEF_ERR1)                                   def_d = DEF_ERR2;
    else                                                          def_d = DEF_IDLE;

    wcnt_d = wcnt_q;
    if (sysahb_hready)          wcnt_d = '0;
    else if (stall && WDOG_EN)  wcnt_d = wcnt_q + 1'b1;

    // A quarantined slave is released as soon as it reports ready again.
    quarantine_d = quarantine_q & ~hreadyout_s;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (abort && (dsel_q == 4'(i))) quarantine_d[i] = 1'b1;
    end

    // An abort beats a simultaneous clear so no timeout event is lost.
    tflag_d  = abort ? 1'b1 : (timeout_clr ? 1'b0 : tflag_q);
    tslave_d = abort ? dsel_q[2:0] : tslave_q;
  end

  // State registers with synchronous reset; reset abandons any data phase in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dsel_q       <= DSEL_NONE;
      def_q        <= DEF_IDLE;
      wcnt_q       <= '0;
      quarantine_q <= '0;
      tflag_q      <= 1'b0;
      tslave_q     <= '0;
    end else begin
      dsel_q       <= dsel_d;
      def_q        <= def_d;
      wcnt_q       <= wcnt_d;
      quarantine_q <= quarantine_d;
      tflag_q      <= tflag_d;
      tslave_q     <= tslave_d;
    end
  end

  assign quarantine    = quarantine_q;
  assign timeout_flag  = tflag_q;
  assign timeout_slave = tslave_q;

endmodule

// File: tb/tb_sysahb_interconnect.sv
// Bench for sysahb_interconnect: two-slave map, default-slave ERROR, watchdog abort and quarantine.
// Transfer completions are checked by a scoreboard monitor; per-cycle details are checked inline.
// A second instance with an overlapping map checks lowest-index priority.
module tb_sysahb_interconnect;

  localparam int         NS     = 2;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic [31:0]        haddr = '0;
  logic [1:0]         htrans = IDLE;
  logic [NS-1:0]      hreadyout_s = 2'b11;
  logic [NS-1:0]      hresp_s = 2'b00;
  logic [32*NS-1:0]   hrdata_s = {32'h5A5A_0002, 32'hA5A5_0001};
  logic               timeout_clr = 1'b0;

  logic               hready, hresp, tflag;
  logic [31:0]        hrdata;
  logic [NS-1:0]      hsel, quar;
  logic [2:0]         tslave;

  logic               o_hready, o_hresp, o_tflag;
  logic [31:0]        o_hrdata;
  logic [NS-1:0]      o_hsel, o_quar;
  logic [2:0]         o_tslave;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   dp_active = 1'b0;

  sysahb_interconnect #(
    .NUM_SLAVES(NS),
    .ADDR_BASE({32'h4000_0000, 32'h2000_0000}),
    .ADDR_MASK({32'hF000_0000, 32'hFFF8_0000}),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sysahb_haddr(haddr), .sysahb_htrans(htrans),
    .sysahb_hready(hready), .sysahb_hresp(hresp), .sysahb_hrdata(hrdata),
    .hsel_s(hsel), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .timeout_flag(tflag), .timeout_slave(tslave), .quarantine(quar),
    .timeout_clr(timeout_clr)
  );

  sysahb_interconnect #(
    .NUM_SLAVES(NS),
    .ADDR_BASE({32'h2000_0000, 32'h2000_0000}),
    .ADDR_MASK({32'hF000_0000, 32'hFFF8_0000}),
    .TIMEOUT_CYCLES(4)
  ) u_ovl (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sysahb_haddr(haddr), .sysahb_htrans(htrans),
    .sysahb_hready(o_hready), .sysahb_hresp(o_hresp), .sysahb_hrdata(o_hrdata),
    .hsel_s(o_hsel), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .timeout_flag(o_tflag), .timeout_slave(o_tslave), .quarantine(o_quar),
    .timeout_clr(timeout_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish in time");
    $fatal(1);
  end

  // Scoreboard monitor: tracks the data phase and pops one expectation per completed transfer.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active && hready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: completion resp=%0b rdata=%h with empty scoreboard", hresp, hrdata);
        end else begin
          mon_e = sb_q.pop_front();
          if (hresp !== mon_e.resp || (!mon_e.resp && hrdata !== mon_e.rdata)) begin
            errors++;
            $display("FAIL sb_xfer: got resp=%0b rdata=%h, want resp=%0b rdata=%h",
                     hresp, hrdata, mon_e.resp, mon_e.rdata);
          end
        end
      end
      if (hready) dp_active = htrans[1];
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    htrans  = IDLE;
    haddr   = '0;
    cyc();
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_bus: got rdy=%0b resp=%0b rdata=%h, want 1 0 0", hready, hresp, hrdata);
    end
    checks++;
    if ({tflag, tslave, quar, hsel} !== {1'b0, 3'd0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_flags: got flag=%0b slave=%0d quar=%b hsel=%b, want 0 0 00 00", tflag, tslave, quar, hsel);
    end
    cyc();
    sys_rst = 1'b0;
    cyc();
  endtask

  task automatic test_read();
    haddr = 32'h2000_0010; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b0, rdata: 32'hA5A5_0001});
    @(negedge sys_clk);
    checks++;
    if (hsel !== 2'b01) begin errors++; $display("FAIL read_s0_hsel: got %b want 01", hsel); end
    cyc();
    haddr = 32'h4000_1234; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b0, rdata: 32'h5A5A_0002});
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL read_s0_data: got rdy=%0b resp=%0b rdata=%h want 1 0 a5a50001", hready, hresp, hrdata);
    end
    checks++;
    if (hsel !== 2'b10) begin errors++; $display("FAIL read_s1_hsel: got %b want 10", hsel); end
    cyc();
    haddr = '0; htrans = IDLE;
    cyc();
  endtask

  task automatic test_overlap();
    haddr = 32'h2000_0000; htrans = IDLE;
    @(negedge sys_clk);
    checks++;
    if (o_hsel !== 2'b01) begin errors++; $display("FAIL overlap_prio: got %b want 01", o_hsel); end
    cyc();
    haddr = 32'h2100_0000;
    @(negedge sys_clk);
    checks++;
    if (o_hsel !== 2'b10) begin errors++; $display("FAIL overlap_s1_only: got %b want 10", o_hsel); end
    cyc();
    haddr = '0;
    cyc();
  endtask

  task automatic test_default();
    haddr = 32'h9000_0000; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b1, rdata: 32'h0});
    @(negedge sys_clk);
    checks++;
    if (hsel !== 2'b00) begin errors++; $display("FAIL def_hsel: got %b want 00", hsel); end
    cyc();
    htrans = IDLE;
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b01) begin errors++; $display("FAIL def_err1: got rdy=%0b resp=%0b want 0 1", hready, hresp); end
    cyc();
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b11) begin errors++; $display("FAIL def_err2: got rdy=%0b resp=%0b want 1 1", hready, hresp); end
    cyc();
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL def_idle_okay: got rdy=%0b resp=%0b rdata=%h want 1 0 0", hready, hresp, hrdata);
    end
    haddr = '0;
    cyc();
  endtask

  // Shared body for watchdog scenarios; clr_at_abort pulses timeout_clr in the abort cycle.
  task automatic test_timeout(input bit clr_at_abort);
    hreadyout_s = 2'b01;
    haddr = 32'h4000_0000; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b1, rdata: 32'h0});
    cyc();
    htrans = IDLE; haddr = '0;
    for (int k = 1; k <= 4; k++) begin
      if (clr_at_abort && k == 4) timeout_clr = 1'b1;
      @(negedge sys_clk);
      checks++;
      if ({hready, hresp} !== 2'b00) begin errors++; $display("FAIL wd_stall%0d: got rdy=%0b resp=%0b want 0 0", k, hready, hresp); end
      cyc();
    end
    timeout_clr = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b01) begin errors++; $display("FAIL wd_err1: got rdy=%0b resp=%0b want 0 1", hready, hresp); end
    checks++;
    if ({tflag, tslave, quar} !== {1'b1, 3'd1, 2'b10}) begin
      errors++;
      $display("FAIL wd_flags: got flag=%0b slave=%0d quar=%b want 1 1 10", tflag, tslave, quar);
    end
    cyc();
    if (!clr_at_abort) begin
      haddr = 32'h4000_0000; htrans = NONSEQ;
      sb_q.push_back('{resp: 1'b1, rdata: 32'h0});
    end
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b11) begin errors++; $display("FAIL wd_err2: got rdy=%0b resp=%0b want 1 1", hready, hresp); end
    if (!clr_at_abort) begin
      checks++;
      if (hsel !== 2'b00) begin errors++; $display("FAIL quar_hsel: got %b want 00", hsel); end
      cyc();
      htrans = IDLE; haddr = '0;
      @(negedge sys_clk);
      checks++;
      if ({hready, hresp} !== 2'b01) begin errors++; $display("FAIL quar_err1: got rdy=%0b resp=%0b want 0 1", hready, hresp); end
      cyc();
      @(negedge sys_clk);
      checks++;
      if ({hready, hresp, quar} !== {1'b1, 1'b1, 2'b10}) begin
        errors++;
        $display("FAIL quar_err2: got rdy=%0b resp=%0b quar=%b want 1 1 10", hready, hresp, quar);
      end
    end else begin
      htrans = IDLE; haddr = '0;
      cyc();
      timeout_clr = 1'b1;
      cyc();
      timeout_clr = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (tflag !== 1'b0) begin errors++; $display("FAIL clr_flag: got %0b want 0", tflag); end
    end
    cyc();
    hreadyout_s = 2'b11;
    cyc();
    @(negedge sys_clk);
    checks++;
    if ({quar, tflag} !== {2'b00, !clr_at_abort}) begin
      errors++;
      $display("FAIL quar_release: got quar=%b flag=%0b want 00 %0b", quar, tflag, !clr_at_abort);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    haddr = 32'h2000_0010; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b0, rdata: 32'hA5A5_0001});
    cyc();
    haddr = 32'h9000_0000; htrans = NONSEQ;
    sb_q.push_back('{resp: 1'b1, rdata: 32'h0});
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL b2b_s0: got rdy=%0b resp=%0b rdata=%h want 1 0 a5a50001", hready, hresp, hrdata);
    end
    cyc();
    haddr = '0; htrans = IDLE;
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b01) begin errors++; $display("FAIL b2b_err1: got rdy=%0b resp=%0b want 0 1", hready, hresp); end
    cyc();
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b11) begin errors++; $display("FAIL b2b_err2: got rdy=%0b resp=%0b want 1 1", hready, hresp); end
    cyc();
  endtask

  task automatic test_reset_mid();
    haddr = 32'h9000_0000; htrans = NONSEQ;
    cyc();
    haddr = '0; htrans = IDLE;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp} !== 2'b01) begin errors++; $display("FAIL rst_mid_err1: got rdy=%0b resp=%0b want 0 1", hready, hresp); end
    cyc();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({hready, hresp, u_dut.def_q} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_after: got rdy=%0b resp=%0b fsm=%0d want 1 0 0", hready, hresp, u_dut.def_q);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_read();
    test_overlap();
    test_default();
    test_timeout(1'b0);
    test_back_to_back();
    test_reset_mid();
    test_timeout(1'b1);
    repeat (2) cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
